// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding tables: mnemonic IDs, opcodes, funct fields and instruction formats.
// Also used by the core controller, so the mnemonic numbering is fixed.
package rv_isa_pkg;

   typedef enum logic [4:0] {
      LUI = 5'd0, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LW, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA
   } mnem_e;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH} fmt_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0]  F7_ALT = 7'b0100000;
   localparam logic [31:0] NOP    = 32'h00000013;

   typedef struct packed {
      logic       ok;
      fmt_e       fmt;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
   } dec_t;

   function automatic dec_t mk(fmt_e f, logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
      dec_t d;
      d.ok  = 1'b1;
      d.fmt = f;
      d.opc = o;
      d.f3  = f3;
      d.f7  = f7;
      return d;
   endfunction

   function automatic dec_t mnem_info(logic [4:0] m);
      dec_t d;
      d = mk(FMT_R, OPC_OP, 3'd0, 7'd0);
      d.ok = 1'b0;
      case (mnem_e'(m))
         LUI:   d = mk(FMT_U,  OPC_LUI,    3'd0, 7'd0);
         AUIPC: d = mk(FMT_U,  OPC_AUIPC,  3'd0, 7'd0);
         JAL:   d = mk(FMT_J,  OPC_JAL,    3'd0, 7'd0);
         JALR:  d = mk(FMT_I,  OPC_JALR,   3'd0, 7'd0);
         BEQ:   d = mk(FMT_B,  OPC_BRANCH, 3'd0, 7'd0);
         BNE:   d = mk(FMT_B,  OPC_BRANCH, 3'd1, 7'd0);
         BLT:   d = mk(FMT_B,  OPC_BRANCH, 3'd4, 7'd0);
         BGE:   d = mk(FMT_B,  OPC_BRANCH, 3'd5, 7'd0);
         BLTU:  d = mk(FMT_B,  OPC_BRANCH, 3'd6, 7'd0);
         BGEU:  d = mk(FMT_B,  OPC_BRANCH, 3'd7, 7'd0);
         LW:    d = mk(FMT_I,  OPC_LOAD,   3'd2, 7'd0);
         SW:    d = mk(FMT_S,  OPC_STORE,  3'd2, 7'd0);
         ADDI:  d = mk(FMT_I,  OPC_OPIMM,  3'd0, 7'd0);
         SLTI:  d = mk(FMT_I,  OPC_OPIMM,  3'd2, 7'd0);
         SLTIU: d = mk(FMT_I,  OPC_OPIMM,  3'd3, 7'd0);
         XORI:  d = mk(FMT_I,  OPC_OPIMM,  3'd4, 7'd0);
         ORI:   d = mk(FMT_I,  OPC_OPIMM,  3'd6, 7'd0);
         ANDI:  d = mk(FMT_I,  OPC_OPIMM,  3'd7, 7'd0);
         SLLI:  d = mk(FMT_SH, OPC_OPIMM,  3'd1, 7'd0);
         SRLI:  d = mk(FMT_SH, OPC_OPIMM,  3'd5, 7'd0);
         SRAI:  d = mk(FMT_SH, OPC_OPIMM,  3'd5, F7_ALT);
         ADD:   d = mk(FMT_R,  OPC_OP,     3'd0, 7'd0);
         SUB:   d = mk(FMT_R,  OPC_OP,     3'd0, F7_ALT);
         SLL:   d = mk(FMT_R,  OPC_OP,     3'd1, 7'd0);
         SLT:   d = mk(FMT_R,  OPC_OP,     3'd2, 7'd0);
         SLTU:  d = mk(FMT_R,  OPC_OP,     3'd3, 7'd0);
         XOR:   d = mk(FMT_R,  OPC_OP,     3'd4, 7'd0);
         OR:    d = mk(FMT_R,  OPC_OP,     3'd6, 7'd0);
         AND:   d = mk(FMT_R,  OPC_OP,     3'd7, 7'd0);
         SRL:   d = mk(FMT_R,  OPC_OP,     3'd5, 7'd0);
         SRA:   d = mk(FMT_R,  OPC_OP,     3'd5, F7_ALT);
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field packer: mnemonic + operands -> instruction word and legality flag.
module rv_instr_pack
   import rv_isa_pkg::*;
(
   input  logic [4:0]         mnem,
   input  logic [4:0]         rd,
   input  logic [4:0]         rs1,
   input  logic [4:0]         rs2,
   input  logic signed [31:0] imm,
   output logic [31:0]        word,
   output logic               legal
);

   function automatic logic in_range(logic signed [31:0] v, logic signed [31:0] lo,
                                     logic signed [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   dec_t d;
   assign d = mnem_info(mnem);

   always_comb begin
      word  = NOP;
      legal = 1'b0;
      case (d.fmt)
         FMT_R: begin
            word  = {d.f7, rs2, rs1, d.f3, rd, d.opc};
            legal = 1'b1;
         end
         FMT_I: begin
            word  = {imm[11:0], rs1, d.f3, rd, d.opc};
            legal = in_range(imm, -32'sd2048, 32'sd2047);
         end
         FMT_SH: begin
            word  = {d.f7, imm[4:0], rs1, d.f3, rd, d.opc};
            legal = in_range(imm, 32'sd0, 32'sd31);
         end
         FMT_S: begin
            word  = {imm[11:5], rs2, rs1, d.f3, imm[4:0], d.opc};
            legal = in_range(imm, -32'sd2048, 32'sd2047);
         end
         FMT_B: begin
            word  = {imm[12], imm[10:5], rs2, rs1, d.f3, imm[4:1], imm[11], d.opc};
            legal = !imm[0] && in_range(imm, -32'sd4096, 32'sd4094);
         end
         FMT_U: begin
            word  = {imm[31:12], rd, d.opc};
            legal = (imm[11:0] == 12'd0);
         end
         FMT_J: begin
            word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, d.opc};
            legal = !imm[0] && in_range(imm, -32'sd1048576, 32'sd1048574);
         end
         default: ;
      endcase
      // table miss covers mnemonic IDs above 30
      if (!d.ok) legal = 1'b0;
   end

endmodule

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder writing packed instructions into imem at incrementing addresses.
// Optional statistics ports stat_words/stat_errs when RVENC_STATS_EN is defined.
module rv_instr_encoder
   import rv_isa_pkg::*;
#(
   parameter int ADDR_W = 10
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4:0]          in_mnem,
   input  logic [4:0]          in_rd,
   input  logic [4:0]          in_rs1,
   input  logic [4:0]          in_rs2,
   input  logic signed [31:0]  in_imm,
   input  logic                in_last,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [31:0]         imem_wdata,
   input  logic                imem_busy,
   output logic                done,
   output logic                err,
   output logic [ADDR_W-1:0]   err_addr
`ifdef RVENC_STATS_EN
  ,output logic [ADDR_W:0]     stat_words,
   output logic [7:0]          stat_errs
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   logic [1:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic              full;
   logic [31:0]       word_p0;
   logic              legal_p0;
   logic              accept, wr_ok, bad;
   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [31:0]       wdata_p1;

   rv_instr_pack u_pack (
      .mnem  (in_mnem),
      .rd    (in_rd),
      .rs1   (in_rs1),
      .rs2   (in_rs2),
      .imm   (in_imm),
      .word  (word_p0),
      .legal (legal_p0)
   );

   assign in_ready   = (state == S_RUN) && (!vld_p1 || !imem_busy);
   assign accept     = in_valid && in_ready;
   assign wr_ok      = accept && legal_p0 && !full;
   assign bad        = accept && !wr_ok;
   assign imem_we    = vld_p1;
   assign imem_addr  = addr_p1;
   assign imem_wdata = wdata_p1;
   assign done       = (state == S_DONE);

   // full marks that the top address was written; the counter never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         full     <= 1'b0;
         err      <= 1'b0;
         err_addr <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state <= S_RUN;
               cnt   <= start_addr;
               full  <= 1'b0;
               err   <= 1'b0;
            end
            S_RUN: begin
               if (accept && in_last) state <= S_DRAIN;
               if (wr_ok) begin
                  if (cnt == ADDR_MAX) full <= 1'b1;
                  else                 cnt  <= cnt + 1'b1;
               end
               if (bad) begin
                  err <= 1'b1;
                  if (!err) err_addr <= cnt;
               end
            end
            S_DRAIN: if (!vld_p1) state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // p0 -> p1: one-deep output register, held while the core owns imem
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         addr_p1  <= '0;
         wdata_p1 <= '0;
      end else if (wr_ok) begin
         vld_p1   <= 1'b1;
         addr_p1  <= cnt;
         wdata_p1 <= word_p0;
      end else if (!imem_busy) begin
         vld_p1   <= 1'b0;
      end
   end

`ifdef RVENC_STATS_EN
   function automatic logic [7:0] sat_inc(logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_words <= '0;
         stat_errs  <= '0;
      end else if (state == S_IDLE && start) begin
         stat_words <= '0;
         stat_errs  <= '0;
      end else begin
         if (wr_ok) stat_words <= stat_words + 1'b1;
         if (bad)   stat_errs  <= sat_inc(stat_errs);
      end
   end
`endif

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed-vector bench for rv_instr_encoder with hand-computed RV32I encodings (ADDR_W=2).
module tb_rv_instr_encoder;
   import rv_isa_pkg::*;

   localparam int AW = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [AW-1:0]       start_addr = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [4:0]          in_mnem = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic signed [31:0]  in_imm = '0;
   logic                in_last = 1'b0;
   logic                imem_we;
   logic [AW-1:0]       imem_addr;
   logic [31:0]         imem_wdata;
   logic                imem_busy = 1'b0;
   logic                done, err;
   logic [AW-1:0]       err_addr;
`ifdef RVENC_STATS_EN
   logic [AW:0]         stat_words;
   logic [7:0]          stat_errs;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   rv_instr_encoder #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mnem    (in_mnem),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .in_last    (in_last),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .imem_busy  (imem_busy),
      .done       (done),
      .err        (err),
      .err_addr   (err_addr)
`ifdef RVENC_STATS_EN
     ,.stat_words (stat_words),
      .stat_errs  (stat_errs)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   // called just after a rising edge; returns just after the edge that took the start pulse
   task automatic do_start(input logic [AW-1:0] a);
      start      = 1'b1;
      start_addr = a;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   // returns #1 after the accepting edge, so the output register is already visible
   task automatic send(input logic [4:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic signed [31:0] imm, input logic last);
      bit ok;
      ok       = 1'b0;
      in_mnem  = m;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_imm   = imm;
      in_last  = last;
      in_valid = 1'b1;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("ready_seen", ok, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, seen, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", in_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_erraddr", err_addr, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single addi
      do_start(2'd0);
      chk("run_ready", in_ready, 1);
      send(ADDI, 5'd1, 5'd0, 5'd0, 32'sd5, 1'b1);
      chk("addi_we", imem_we, 1);
      chk("addi_addr", imem_addr, 0);
      chk("addi_data", imem_wdata, 32'h00500093);
      wait_done("addi_done");

      // streamed U/B/S formats
      do_start(2'd0);
      send(LUI, 5'd2, 5'd0, 5'd0, 32'sh12345000, 1'b0);
      chk("lui_we", imem_we, 1);
      chk("lui_addr", imem_addr, 0);
      chk("lui_data", imem_wdata, 32'h12345137);
      send(BEQ, 5'd0, 5'd1, 5'd2, 32'sd8, 1'b0);
      chk("beq_addr", imem_addr, 1);
      chk("beq_data", imem_wdata, 32'h00208463);
      send(SW, 5'd0, 5'd1, 5'd2, 32'sd4, 1'b1);
      chk("sw_addr", imem_addr, 2);
      chk("sw_data", imem_wdata, 32'h0020A223);
      chk("sw_nodone", done, 0);
      wait_done("stream_done");

      // funct7 alternates and back-pressure from imem_busy
      do_start(2'd0);
      send(SUB, 5'd3, 5'd1, 5'd2, 32'sd0, 1'b0);
      chk("sub_addr", imem_addr, 0);
      chk("sub_data", imem_wdata, 32'h402081B3);
      imem_busy = 1'b1;
      in_mnem   = SRAI;
      in_rd     = 5'd4;
      in_rs1    = 5'd1;
      in_rs2    = 5'd0;
      in_imm    = 32'sd3;
      in_last   = 1'b1;
      in_valid  = 1'b1;
      #1;
      chk("busy_ready0", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("busy_ready", in_ready, 0);
         chk("busy_we", imem_we, 1);
         chk("busy_addr", imem_addr, 0);
         chk("busy_data", imem_wdata, 32'h402081B3);
      end
      imem_busy = 1'b0;
      #1;
      chk("unbusy_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("srai_we", imem_we, 1);
      chk("srai_addr", imem_addr, 1);
      chk("srai_data", imem_wdata, 32'h4030D213);
      wait_done("busy_done");

      // illegal immediates: consumed, nothing written, address held
      do_start(2'd1);
      send(ADDI, 5'd1, 5'd0, 5'd0, 32'sd2048, 1'b0);
      chk("ill_addi_we", imem_we, 0);
      chk("ill_addi_err", err, 1);
      chk("ill_addi_erraddr", err_addr, 1);
      send(BEQ, 5'd0, 5'd1, 5'd2, 32'sd3, 1'b0);
      chk("ill_beq_we", imem_we, 0);
      chk("ill_beq_err", err, 1);
      chk("ill_beq_erraddr", err_addr, 1);
      send(ADDI, 5'd1, 5'd0, 5'd0, 32'sd5, 1'b1);
      chk("after_ill_addr", imem_addr, 1);
      chk("after_ill_data", imem_wdata, 32'h00500093);
      wait_done("ill_done");
      chk("err_sticky", err, 1);

      // address overflow at the top of a 4-word imem
      do_start(2'd2);
      chk("start_clr_err", err, 0);
      send(ADDI, 5'd1, 5'd0, 5'd0, 32'sd5, 1'b0);
      chk("ovf_w0_addr", imem_addr, 2);
      chk("ovf_w0_data", imem_wdata, 32'h00500093);
      send(ADDI, 5'd1, 5'd0, 5'd0, 32'sd6, 1'b0);
      chk("ovf_w1_addr", imem_addr, 3);
      chk("ovf_w1_data", imem_wdata, 32'h00600093);
      send(ADDI, 5'd1, 5'd0, 5'd0, 32'sd7, 1'b0);
      chk("ovf_drop_we", imem_we, 0);
      chk("ovf_err", err, 1);
      chk("ovf_erraddr", err_addr, 3);
      chk("ovf_addr_hold", imem_addr, 3);

      // asynchronous abort
      rst_n = 1'b0;
      #1;
      chk("abort_ready", in_ready, 0);
      chk("abort_we", imem_we, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      chk("abort_addr", imem_addr, 0);
      chk("abort_wdata", imem_wdata, 0);
      chk("abort_erraddr", err_addr, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
